uart_cmd_responder: RTL and testbench

Byte-level command responder for the host link. It sits between the UART receive stream and the UART transmit stream. It parses single-byte-opcode read/write commands arriving from the host, performs accesses on a simple synchronous register bus, and returns a one-byte response. This gives the host link its far-end peer: the host initiates, this block answers.

---
 rtl/uart_cmd_responder.sv | 176 +++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_responder.sv
// Byte-level command responder for the host UART link.
// Parses 0x57 addr data (write) and 0x52 addr (read) commands from the receive stream.
// Each command performs one register bus access and returns a single response byte:
// 0x4B for a write, the read data for a read, and 0x3F for an unknown opcode.
// Optional feature: define UART_CMD_TIMEOUT_EN to abort partial commands after
// TIMEOUT_CYCLES idle cycles in GET_ADDR or GET_DATA.
module uart_cmd_responder #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [7:0]            reg_rdata,
  output logic                  busy,
  output logic [7:0]            err_count
);

  localparam logic [7:0] OpWrite  = 8'h57;
  localparam logic [7:0] OpRead   = 8'h52;
  localparam logic [7:0] RespAck  = 8'h4B;
  localparam logic [7:0] RespBad  = 8'h3F;

  if (ADDR_WIDTH == 0 || ADDR_WIDTH > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_cmd_responder: illegal ADDR_WIDTH or TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    StIdle, StGetAddr, StGetData, StWrite, StRead, StReadWait, StResp
  } state_e;

  state_e                state_q, state_d;
  logic                  op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [7:0]            resp_q, resp_d;
  logic [7:0]            err_q, err_d;
  logic [7:0]            err_inc;
  logic                  ready_en_q;
  logic                  accept;
  logic                  timeout_hit;

  // ready_en_q keeps tready low while in reset and through the first edge after release
  assign s_axis_tready = ready_en_q &&
                         (state_q == StIdle || state_q == StGetAddr || state_q == StGetData);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign err_inc       = err_q + {7'd0, (err_q != 8'hFF)};

  assign m_axis_tdata  = resp_q;
  assign reg_addr      = addr_q;
  assign reg_wdata     = wdata_q;
  assign err_count     = err_q;
  assign busy          = (state_q != StIdle);

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            waiting;

  assign waiting     = (state_q == StGetAddr || state_q == StGetData);
  assign timeout_hit = waiting && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter: cleared by any accepted byte and outside the byte-wait states
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (accept || !waiting) cnt_d = '0;
  end

  // Timeout counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state, datapath next values and strobes
  always_comb begin
    state_d       = state_q;
    op_wr_d       = op_wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    resp_d        = resp_q;
    err_d         = err_q;
    reg_we        = 1'b0;
    reg_re        = 1'b0;
    m_axis_tvalid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (s_axis_tdata == OpWrite) begin
            op_wr_d = 1'b1;
            state_d = StGetAddr;
          end else if (s_axis_tdata == OpRead) begin
            op_wr_d = 1'b0;
            state_d = StGetAddr;
          end else begin
            resp_d  = RespBad;
            err_d   = err_inc;
            state_d = StResp;
          end
        end
      end
      StGetAddr: begin
        // An accepted byte takes priority over a simultaneous timeout
        if (accept) begin
          addr_d  = s_axis_tdata[ADDR_WIDTH-1:0];
          state_d = op_wr_q ? StGetData : StRead;
        end else if (timeout_hit) begin
          err_d   = err_inc;
          state_d = StIdle;
        end
      end
      StGetData: begin
        if (accept) begin
          wdata_d = s_axis_tdata;
          state_d = StWrite;
        end else if (timeout_hit) begin
          err_d   = err_inc;
          state_d = StIdle;
        end
      end
      StWrite: begin
        reg_we  = 1'b1;
        resp_d  = RespAck;
        state_d = StResp;
      end
      StRead: begin
        reg_re  = 1'b1;
        state_d = StReadWait;
      end
      StReadWait: begin
        resp_d  = reg_rdata;
        state_d = StResp;
      end
      StResp: begin
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_q     <= '0;
      err_q      <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      resp_q     <= resp_d;
      err_q      <= err_d;
      ready_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed plus randomized bench for uart_cmd_responder.
// Expected responses come from a shadow register array and saturating error tally in the bench.
// The timeout scenario is compiled only when UART_CMD_TIMEOUT_EN is defined.
module tb_uart_cmd_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic [7:0] err_count;

  int vectors    = 0;
  int miscompares = 0;

  uart_cmd_responder #(
    .ADDR_WIDTH    (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_we       (reg_we),
    .reg_re       (reg_re),
    .reg_rdata    (reg_rdata),
    .busy         (busy),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  // Register bus peripheral: registered read data, valid the cycle after reg_re
  logic [7:0] mem [256];
  int we_cnt   = 0;
  int re_cnt   = 0;
  int resp_cnt = 0;
  always @(posedge clk) begin
    if (reg_we) mem[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= mem[reg_addr];
    if (reg_we) we_cnt <= we_cnt + 1;
    if (reg_re) re_cnt <= re_cnt + 1;
    if (m_axis_tvalid && m_axis_tready) resp_cnt <= resp_cnt + 1;
  end

  // Reference state
  logic [7:0] shadow [256];
  int         waddrs [$];
  int         exp_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a byte and return #1 after the edge on which it was accepted
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b;
    while (!s_axis_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_budget", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  // Wait for tvalid; cyc counts cycles from the last accept (cycle 1 = cycle after accept edge)
  task automatic get_resp(output logic [7:0] r, output int cyc);
    cyc = 1;
    while (!m_axis_tvalid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!m_axis_tvalid) check("resp_budget", 32'(cyc), 32'd0);
    r = m_axis_tdata;
    if (m_axis_tready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] r;
    int cyc, we0;
    we0 = we_cnt;
    send_byte(8'h57);
    send_byte(a);
    send_byte(d);
    check("wr_we", 32'(reg_we), 32'd1);
    check("wr_addr", 32'(reg_addr), 32'(a));
    check("wr_wdata", 32'(reg_wdata), 32'(d));
    get_resp(r, cyc);
    check("wr_resp", 32'(r), 32'h4B);
    check("wr_latency", 32'(cyc), 32'd2);
    check("wr_once", 32'(we_cnt - we0), 32'd1);
    shadow[a] = d;
    waddrs.push_back(int'(a));
  endtask

  task automatic do_read(input logic [7:0] a);
    logic [7:0] r;
    int cyc, re0, we0;
    re0 = re_cnt;
    we0 = we_cnt;
    send_byte(8'h52);
    send_byte(a);
    check("rd_re", 32'(reg_re), 32'd1);
    check("rd_addr", 32'(reg_addr), 32'(a));
    get_resp(r, cyc);
    check("rd_data", 32'(r), 32'(shadow[a]));
    check("rd_latency", 32'(cyc), 32'd3);
    check("rd_once", 32'(re_cnt - re0), 32'd1);
    check("rd_no_we", 32'(we_cnt - we0), 32'd0);
  endtask

  task automatic do_bad(input logic [7:0] b);
    logic [7:0] r;
    int cyc;
    send_byte(b);
    get_resp(r, cyc);
    check("bad_resp", 32'(r), 32'h3F);
    exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    check("bad_errcnt", 32'(err_count), 32'(exp_err));
  endtask

  initial begin
    logic [7:0] a, d, b;
    int k, snap, we0, re0;

    rst           = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    m_axis_tready = 1'b1;

    // Reset state
    #3;
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_we_re", 32'({reg_we, reg_re}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_s_tready_lo", 32'(s_axis_tready), 32'd0);
    @(posedge clk);
    #1;
    check("rel_s_tready_hi", 32'(s_axis_tready), 32'd1);

    // Directed write and read
    do_write(8'h12, 8'hA5);
    do_write(8'h34, 8'hC3);
    do_read(8'h34);

    // Randomized command mix
    for (int i = 0; i < 30; i++) begin
      k = int'($urandom_range(0, 2));
      if (k == 0) begin
        a = 8'($urandom);
        d = 8'($urandom);
        do_write(a, d);
      end else if (k == 1) begin
        a = 8'(waddrs[$urandom_range(0, waddrs.size() - 1)]);
        do_read(a);
      end else begin
        b = 8'($urandom);
        if (b == 8'h57 || b == 8'h52) b = 8'h00;
        do_bad(b);
      end
    end

    // Backpressure on the response
    m_axis_tready = 1'b0;
    send_byte(8'h57);
    send_byte(8'h40);
    send_byte(8'h99);
    shadow[8'h40] = 8'h99;
    waddrs.push_back(32'h40);
    k = 0;
    while (!m_axis_tvalid && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    snap = resp_cnt;
    for (int i = 0; i < 20; i++) begin
      check("bp_tvalid", 32'(m_axis_tvalid), 32'd1);
      check("bp_tdata", 32'(m_axis_tdata), 32'h4B);
      check("bp_s_tready", 32'(s_axis_tready), 32'd0);
      @(posedge clk);
      #1;
    end
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_tvalid_drop", 32'(m_axis_tvalid), 32'd0);
    check("bp_one_resp", 32'(resp_cnt - snap), 32'd1);

    // Unknown opcodes and error counter saturation
    we0 = we_cnt;
    re0 = re_cnt;
    snap = resp_cnt;
    do_bad(8'h00);
    for (int i = 0; i < 300; i++) do_bad(8'hFF);
    check("sat_err", 32'(err_count), 32'hFF);
    check("sat_resp_cnt", 32'(resp_cnt - snap), 32'd301);
    check("sat_no_we", 32'(we_cnt - we0), 32'd0);
    check("sat_no_re", 32'(re_cnt - re0), 32'd0);

    do_write(8'h01, 8'h5A);
    do_write(8'h02, 8'h77);

    // Reset in the middle of a write command
    we0 = we_cnt;
    snap = resp_cnt;
    send_byte(8'h57);
    send_byte(8'h12);
    rst = 1'b0;
    #1;
    exp_err = 0;
    check("mid_rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("mid_rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("mid_rst_addr", 32'(reg_addr), 32'd0);
    check("mid_rst_wdata", 32'(reg_wdata), 32'd0);
    check("mid_rst_err", 32'(err_count), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rel_s_tready", 32'(s_axis_tready), 32'd1);
    do_read(8'h01);
    check("mid_rst_no_we", 32'(we_cnt - we0), 32'd0);
    check("mid_rst_resp_cnt", 32'(resp_cnt - snap), 32'd1);

`ifdef UART_CMD_TIMEOUT_EN
    // Partial command abandoned by the inter-byte timeout
    we0 = we_cnt;
    snap = resp_cnt;
    send_byte(8'h57);
    repeat (10) @(posedge clk);
    #1;
    check("to_still_busy", 32'(busy), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    exp_err = exp_err + 1;
    check("to_idle", 32'(busy), 32'd0);
    check("to_no_resp", 32'(resp_cnt - snap), 32'd0);
    check("to_err", 32'(err_count), 32'(exp_err));
    check("to_no_we", 32'(we_cnt - we0), 32'd0);
    do_read(8'h02);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
